// File: rtl/led_rotate_monitor.sv
// led_rotate_monitor
// Watches an 8-bit rotating LED pattern. The first accepted step sets the
// rotation direction. Each later step in that direction is counted and timed.
// Sticky flags record illegal pattern jumps and out-of-tolerance step timing.
module led_rotate_monitor #(
    parameter int unsigned CLK_FREQ    = 25_000_000,
    parameter int unsigned STEP_CYCLES = CLK_FREQ / 4,
    parameter int unsigned TOL         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  leds_in,
    output logic        locked,
    output logic        dir,
    output logic [15:0] step_count,
    output logic [31:0] last_interval,
    output logic        rot_error,
    output logic        timing_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    // Interval bounds are kept 33 bits wide so that gap+1 never wraps in a compare.
    localparam logic [32:0] LO_LIMIT    = 33'(STEP_CYCLES) - 33'(TOL);
    localparam logic [32:0] HI_LIMIT    = 33'(STEP_CYCLES) + 33'(TOL);
    localparam logic [32:0] STALL_LIMIT = HI_LIMIT + 33'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_ref;
    logic [7:0]  w_ref_nxt;
    logic [31:0] r_gap;
    logic [31:0] w_gap_nxt;
    logic        r_dir;
    logic        w_dir_nxt;
    logic [15:0] r_step_count;
    logic [15:0] w_step_count_nxt;
    logic [31:0] r_last_interval;
    logic [31:0] w_last_interval_nxt;
    logic        r_rot_error;
    logic        w_rot_error_nxt;
    logic        r_timing_error;
    logic        w_timing_error_nxt;

    logic [7:0]  w_rotl;
    logic [7:0]  w_rotr;
    logic        w_change;
    logic        w_dir_match;
    logic [32:0] w_gap_p1;
    logic [31:0] w_gap_sat;
    logic [15:0] w_count_inc;

    assign w_rotl      = {r_ref[6:0], r_ref[7]};
    assign w_rotr      = {r_ref[0], r_ref[7:1]};
    assign w_change    = (r_state != S_IDLE) && (leds_in != r_ref);
    assign w_dir_match = r_dir ? (leds_in == w_rotr) : (leds_in == w_rotl);
    assign w_gap_p1    = {1'b0, r_gap} + 33'd1;
    assign w_gap_sat   = (&r_gap) ? r_gap : w_gap_p1[31:0];
    assign w_count_inc = (&r_step_count) ? r_step_count : r_step_count + 16'd1;

    assign locked        = (r_state == S_TRACK);
    assign dir           = r_dir;
    assign step_count    = r_step_count;
    assign last_interval = r_last_interval;
    assign rot_error     = r_rot_error;
    assign timing_error  = r_timing_error;

    // State and datapath registers; rst forces everything to its idle value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ref           <= '0;
            r_gap           <= '0;
            r_dir           <= 1'b0;
            r_step_count    <= '0;
            r_last_interval <= '0;
            r_rot_error     <= 1'b0;
            r_timing_error  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ref           <= w_ref_nxt;
            r_gap           <= w_gap_nxt;
            r_dir           <= w_dir_nxt;
            r_step_count    <= w_step_count_nxt;
            r_last_interval <= w_last_interval_nxt;
            r_rot_error     <= w_rot_error_nxt;
            r_timing_error  <= w_timing_error_nxt;
        end
    end

    // Next-state logic: acquire the pattern, learn the direction, then track steps and timing.
    always_comb begin
        w_state_nxt         = r_state;
        w_ref_nxt           = r_ref;
        w_gap_nxt           = w_gap_sat;
        w_dir_nxt           = r_dir;
        w_step_count_nxt    = r_step_count;
        w_last_interval_nxt = r_last_interval;
        w_rot_error_nxt     = r_rot_error;
        w_timing_error_nxt  = r_timing_error;

        if (clear) begin
            // clear has priority over a change sampled on the same edge.
            w_state_nxt         = S_IDLE;
            w_ref_nxt           = '0;
            w_gap_nxt           = '0;
            w_dir_nxt           = 1'b0;
            w_step_count_nxt    = '0;
            w_last_interval_nxt = '0;
            w_rot_error_nxt     = 1'b0;
            w_timing_error_nxt  = 1'b0;
        end else begin
            if (w_change) begin
                w_ref_nxt = leds_in;
                w_gap_nxt = '0;
            end

            case (r_state)
                S_IDLE: begin
                    w_ref_nxt   = leds_in;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_ARMED;
                end

                S_ARMED: begin
                    if (w_change) begin
                        // A left rotation is preferred when both directions match (e.g. 55 -> AA).
                        if (leds_in == w_rotl) begin
                            w_dir_nxt        = 1'b0;
                            w_step_count_nxt = w_count_inc;
                            w_state_nxt      = S_TRACK;
                        end else if (leds_in == w_rotr) begin
                            w_dir_nxt        = 1'b1;
                            w_step_count_nxt = w_count_inc;
                            w_state_nxt      = S_TRACK;
                        end else begin
                            w_rot_error_nxt = 1'b1;
                        end
                    end
                end

                S_TRACK: begin
                    if (w_change) begin
                        if (w_dir_match) begin
                            w_step_count_nxt    = w_count_inc;
                            w_last_interval_nxt = w_gap_sat;
                            if ((w_gap_p1 < LO_LIMIT) || (w_gap_p1 > HI_LIMIT)) begin
                                w_timing_error_nxt = 1'b1;
                            end
                        end else begin
                            w_rot_error_nxt = 1'b1;
                            w_state_nxt     = S_ARMED;
                        end
                    end else if (w_gap_p1 == STALL_LIMIT) begin
                        w_timing_error_nxt = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_rotate_monitor.sv
// Directed, table-driven bench for led_rotate_monitor.
// Main instance: STEP_CYCLES=8, TOL=1. Second instance: STEP_CYCLES=2, TOL=1.
// The second instance steps every clock to reach step_count saturation.
module tb_led_rotate_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear;
    logic [7:0]  leds;
    logic        locked;
    logic        dir;
    logic [15:0] step_count;
    logic [31:0] last_interval;
    logic        rot_error;
    logic        timing_error;

    logic        rst_s;
    logic        clear_s;
    logic [7:0]  leds_s;
    logic        locked_s;
    logic        dir_s;
    logic [15:0] step_count_s;
    logic [31:0] last_interval_s;
    logic        rot_error_s;
    logic        timing_error_s;

    int checks   = 0;
    int failures = 0;
    bit sat_done = 1'b0;

    led_rotate_monitor #(
        .CLK_FREQ    (32),
        .STEP_CYCLES (8),
        .TOL         (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .leds_in       (leds),
        .locked        (locked),
        .dir           (dir),
        .step_count    (step_count),
        .last_interval (last_interval),
        .rot_error     (rot_error),
        .timing_error  (timing_error)
    );

    led_rotate_monitor #(
        .CLK_FREQ    (8),
        .STEP_CYCLES (2),
        .TOL         (1)
    ) dut_sat (
        .clk           (clk),
        .rst           (rst_s),
        .clear         (clear_s),
        .leds_in       (leds_s),
        .locked        (locked_s),
        .dir           (dir_s),
        .step_count    (step_count_s),
        .last_interval (last_interval_s),
        .rot_error     (rot_error_s),
        .timing_error  (timing_error_s)
    );

    typedef struct {
        logic        clr;
        logic [7:0]  leds;
        int          hold;
        logic        e_locked;
        logic        e_dir;
        logic [15:0] e_cnt;
        logic [31:0] e_li;
        logic        e_rerr;
        logic        e_terr;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(input logic clr, input logic [7:0] l, input int h,
                                input logic el, input logic ed, input logic [15:0] ec,
                                input logic [31:0] eli, input logic er, input logic et);
        vec_t v;
        v.clr = clr; v.leds = l; v.hold = h;
        v.e_locked = el; v.e_dir = ed; v.e_cnt = ec; v.e_li = eli;
        v.e_rerr = er; v.e_terr = et;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic el, input logic ed,
                             input logic [15:0] ec, input logic [31:0] eli,
                             input logic er, input logic et);
        chk({tag, ".locked"},        32'(locked),        32'(el));
        chk({tag, ".dir"},           32'(dir),           32'(ed));
        chk({tag, ".step_count"},    32'(step_count),    32'(ec));
        chk({tag, ".last_interval"}, last_interval,      eli);
        chk({tag, ".rot_error"},     32'(rot_error),     32'(er));
        chk({tag, ".timing_error"},  32'(timing_error),  32'(et));
    endtask

    // Called on a falling edge: drive one vector, hold it for 'hold' rising edges, then check.
    task automatic apply(input int idx);
        clear = vt[idx].clr;
        leds  = vt[idx].leds;
        repeat (vt[idx].hold) @(negedge clk);
        clear = 1'b0;
        check_all($sformatf("v%0d", idx), vt[idx].e_locked, vt[idx].e_dir, vt[idx].e_cnt,
                  vt[idx].e_li, vt[idx].e_rerr, vt[idx].e_terr);
    endtask

    initial begin
        //            clr leds  hold  lck dir cnt li rerr terr
        vt[0]  = mk(0, 8'h1F, 1,  0, 0, 0,  0,  0, 0);
        vt[1]  = mk(0, 8'h3E, 8,  1, 0, 1,  0,  0, 0);
        vt[2]  = mk(0, 8'h7C, 8,  1, 0, 2,  8,  0, 0);
        vt[3]  = mk(0, 8'hF8, 8,  1, 0, 3,  8,  0, 0);
        vt[4]  = mk(0, 8'hF1, 8,  1, 0, 4,  8,  0, 0);
        vt[5]  = mk(0, 8'hE3, 8,  1, 0, 5,  8,  0, 0);
        vt[6]  = mk(0, 8'hC7, 8,  1, 0, 6,  8,  0, 0);
        vt[7]  = mk(0, 8'h8F, 8,  1, 0, 7,  8,  0, 0);
        vt[8]  = mk(0, 8'h1F, 8,  1, 0, 8,  8,  0, 0);
        vt[9]  = mk(0, 8'h3E, 8,  1, 0, 9,  8,  0, 0);
        vt[10] = mk(0, 8'h55, 8,  0, 0, 9,  8,  1, 0);
        vt[11] = mk(0, 8'hAA, 8,  1, 0, 10, 8,  1, 0);
        vt[12] = mk(0, 8'h55, 8,  1, 0, 11, 8,  1, 0);
        vt[13] = mk(1, 8'hAA, 1,  0, 0, 0,  0,  0, 0);
        vt[14] = mk(0, 8'h1F, 1,  0, 0, 0,  0,  0, 0);
        vt[15] = mk(0, 8'h8F, 8,  1, 1, 1,  0,  0, 0);
        vt[16] = mk(0, 8'hC7, 8,  1, 1, 2,  8,  0, 0);
        vt[17] = mk(1, 8'hE3, 1,  0, 0, 0,  0,  0, 0);
        vt[18] = mk(0, 8'hE3, 1,  0, 0, 0,  0,  0, 0);
        vt[19] = mk(0, 8'hF1, 7,  1, 1, 1,  0,  0, 0);
        vt[20] = mk(0, 8'hF8, 9,  1, 1, 2,  7,  0, 0);
        vt[21] = mk(0, 8'h7C, 6,  1, 1, 3,  9,  0, 0);
        vt[22] = mk(0, 8'h3E, 8,  1, 1, 4,  6,  0, 1);
        vt[23] = mk(1, 8'h3E, 1,  0, 0, 0,  0,  0, 0);
        vt[24] = mk(0, 8'h3E, 1,  0, 0, 0,  0,  0, 0);
        vt[25] = mk(0, 8'h1F, 12, 1, 1, 1,  0,  0, 1);
        vt[26] = mk(0, 8'h8F, 8,  1, 1, 2,  12, 0, 1);

        rst   = 1'b1;
        clear = 1'b0;
        leds  = 8'h1F;
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // Acquire and lock once, then hit rst between clock edges.
        rst = 1'b0;
        @(negedge clk);
        leds = 8'h3E;
        repeat (8) @(negedge clk);
        check_all("prerst", 1, 0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        leds = 8'h1F;
        rst  = 1'b0;

        for (int i = 0; i <= 16; i++) apply(i);

        // Stall: one right step to E3, then hold the pattern in TRACK.
        leds = 8'hE3;
        @(negedge clk);
        check_all("stall_step", 1, 1, 3, 8, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("stall_quiet%0d", k), 32'(timing_error), 32'd0);
        end
        @(negedge clk);
        chk("stall_flag", 32'(timing_error), 32'd1);
        chk("stall_locked", 32'(locked), 32'd1);
        chk("stall_count", 32'(step_count), 32'd3);

        for (int i = 17; i <= 26; i++) apply(i);

        for (int c = 0; c < 80000 && !sat_done; c++) @(negedge clk);
        if (!sat_done) begin
            checks++;
            failures++;
            $display("FAIL sat_timeout: got done=0 expected done=1");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Saturation run: a rotation every clock drives step_count up to its ceiling.
    initial begin
        rst_s   = 1'b1;
        clear_s = 1'b0;
        leds_s  = 8'h01;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 65534; i++) begin
            leds_s = {leds_s[6:0], leds_s[7]};
            @(negedge clk);
        end
        chk("sat_fffe", 32'(step_count_s), 32'h0000_FFFE);
        chk("sat_li", last_interval_s, 32'd1);
        chk("sat_locked", 32'(locked_s), 32'd1);
        chk("sat_flags", {30'd0, rot_error_s, timing_error_s}, 32'd0);
        for (int j = 0; j < 2; j++) begin
            leds_s = {leds_s[6:0], leds_s[7]};
            @(negedge clk);
            chk($sformatf("sat_ffff%0d", j), 32'(step_count_s), 32'h0000_FFFF);
        end
        chk("sat_dir", 32'(dir_s), 32'd0);
        sat_done = 1'b1;
    end

endmodule
